// File: rtl/wb_mmio_ctrl_if.sv
// rtl/wb_mmio_ctrl_if.sv - Wishbone-style bus bundle between a bus master and wb_mmio_ctrl
//
// Signals: CYC/STB/WE qualify a cycle, ADDR is a word address, DAT_I carries
// write data towards the slave, DAT_O carries read data back, ACK ends the cycle.
interface wishbone_if #(
    parameter int AW = 16
) ();
    logic          CYC;
    logic          STB;
    logic          WE;
    logic [AW-1:0] ADDR;
    logic [31:0]   DAT_I;
    logic [31:0]   DAT_O;
    logic          ACK;

    modport master (
        output CYC, STB, WE, ADDR, DAT_I,
        input  DAT_O, ACK
    );

    modport slave (
        input  CYC, STB, WE, ADDR, DAT_I,
        output DAT_O, ACK
    );
endinterface

// File: rtl/wb_mmio_ctrl.sv
// rtl/wb_mmio_ctrl.sv - Wishbone slave fanning single accesses out to 64 MMIO register slots
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   wb                Wishbone slave side (CYC, STB, WE, ADDR, DAT_I, DAT_O, ACK)
//   slot_cs           one-hot slot select, valid from REQ through ACK
//   slot_rd, slot_wr  single-cycle access strobes issued in REQ
//   slot_reg_addr     register index inside the selected slot
//   slot_wr_data      write data for the selected slot
//   slot_rd_data      packed read data of every slot
//   slot_ready        per-slot completion flag (may be tied high)
//   err_clr           clears bus_err (a simultaneous new error wins)
//   bus_err           sticky timeout / unmapped-access flag
//   err_addr          word address of the most recent error
module wb_mmio_ctrl #(
    parameter int          N_SLOTS         = 64,
    parameter int          REG_AW          = 5,
    parameter int          TIMEOUT         = 16,
    parameter logic [31:0] ERR_DATA        = 32'hDEAD_BEEF,
    parameter int          MMIO_ADDR_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    wishbone_if.slave                       wb,
    output logic [N_SLOTS-1:0]              slot_cs,
    output logic                            slot_rd,
    output logic                            slot_wr,
    output logic [REG_AW-1:0]               slot_reg_addr,
    output logic [31:0]                     slot_wr_data,
    input  logic [N_SLOTS-1:0][31:0]        slot_rd_data,
    input  logic [N_SLOTS-1:0]              slot_ready,
    input  logic                            err_clr,
    output logic                            bus_err,
    output logic [MMIO_ADDR_WIDTH-1:0]      err_addr
);
    localparam int SW      = $clog2(N_SLOTS);
    localparam int DEC_LSB = REG_AW + SW;      // first address bit above the slot field
    localparam int CW      = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t                     state_q;
    logic [MMIO_ADDR_WIDTH-1:0] addr_q;
    logic                       we_q;
    logic [CW-1:0]              cnt_q;
    logic                       ack_q;
    logic [31:0]                dat_o_q;
    logic [N_SLOTS-1:0]         cs_q;
    logic                       rd_q;
    logic                       wr_q;
    logic [REG_AW-1:0]          reg_addr_q;
    logic [31:0]                wr_data_q;
    logic                       bus_err_q;
    logic [MMIO_ADDR_WIDTH-1:0] err_addr_q;

    logic [SW-1:0] in_idx;
    logic          in_mapped;
    logic [SW-1:0] sel_idx;
    logic          sel_mapped;

    // Any address bit above the slot field set means no slot exists there.
    assign in_idx     = wb.ADDR[DEC_LSB-1:REG_AW];
    assign in_mapped  = ~|wb.ADDR[MMIO_ADDR_WIDTH-1:DEC_LSB];
    assign sel_idx    = addr_q[DEC_LSB-1:REG_AW];
    assign sel_mapped = ~|addr_q[MMIO_ADDR_WIDTH-1:DEC_LSB];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            dat_o_q    <= '0;
            cs_q       <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            // Error-setting branches below assign later, so a new error beats err_clr.
            if (err_clr) begin
                bus_err_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (wb.CYC && wb.STB) begin
                        addr_q  <= wb.ADDR;
                        we_q    <= wb.WE;
                        cnt_q   <= '0;
                        state_q <= S_REQ;
                        if (in_mapped) begin
                            cs_q       <= N_SLOTS'(1) << in_idx;
                            rd_q       <= ~wb.WE;
                            wr_q       <= wb.WE;
                            reg_addr_q <= wb.ADDR[REG_AW-1:0];
                            wr_data_q  <= wb.DAT_I;
                        end
                    end
                end

                S_REQ, S_WAIT: begin
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (!wb.CYC) begin
                        // Master gave up: quietly drop the access without ACK.
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                        cs_q       <= '0;
                        reg_addr_q <= '0;
                        wr_data_q  <= '0;
                    end else if (!sel_mapped || (!slot_ready[sel_idx] && cnt_q == CW'(TIMEOUT - 1))) begin
                        ack_q      <= 1'b1;
                        dat_o_q    <= ERR_DATA;
                        bus_err_q  <= 1'b1;
                        err_addr_q <= addr_q;
                        state_q    <= S_ACK;
                    end else if (slot_ready[sel_idx]) begin
                        ack_q   <= 1'b1;
                        dat_o_q <= we_q ? 32'h0 : slot_rd_data[sel_idx];
                        state_q <= S_ACK;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= S_WAIT;
                    end
                end

                S_ACK: begin
                    ack_q      <= 1'b0;
                    cnt_q      <= '0;
                    cs_q       <= '0;
                    reg_addr_q <= '0;
                    wr_data_q  <= '0;
                    state_q    <= S_RELEASE;
                end

                S_RELEASE: begin
                    // Hold here until the master retires the request so it is never ACKed twice.
                    if (!wb.STB || !wb.CYC) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb.ACK        = ack_q;
    assign wb.DAT_O      = dat_o_q;
    assign slot_cs       = cs_q;
    assign slot_rd       = rd_q;
    assign slot_wr       = wr_q;
    assign slot_reg_addr = reg_addr_q;
    assign slot_wr_data  = wr_data_q;
    assign bus_err       = bus_err_q;
    assign err_addr      = err_addr_q;
endmodule

// File: tb/tb_wb_mmio_ctrl.sv
// tb/tb_wb_mmio_ctrl.sv - scoreboard testbench for wb_mmio_ctrl
module tb_wb_mmio_ctrl;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [63:0]       slot_cs;
    logic              slot_rd;
    logic              slot_wr;
    logic [4:0]        slot_reg_addr;
    logic [31:0]       slot_wr_data;
    logic [63:0][31:0] slot_rd_data;
    logic [63:0]       slot_ready;
    logic              err_clr;
    logic              bus_err;
    logic [15:0]       err_addr;

    wishbone_if #(.AW(16)) wb ();

    wb_mmio_ctrl #(
        .N_SLOTS(64), .REG_AW(5), .TIMEOUT(16),
        .ERR_DATA(32'hDEAD_BEEF), .MMIO_ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .wb(wb),
        .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
        .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data(slot_rd_data), .slot_ready(slot_ready),
        .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          ack_cnt = 0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          cs_cycles = 0;
    logic [63:0] cap_cs = '0;
    logic [4:0]  cap_reg = '0;
    logic [31:0] cap_wd = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe observer.
    always @(negedge clk) begin
        if (slot_rd) rd_pulses++;
        if (slot_wr) wr_pulses++;
        if (slot_cs != 64'h0) cs_cycles++;
        if (slot_rd || slot_wr) begin
            cap_cs  = slot_cs;
            cap_reg = slot_reg_addr;
            cap_wd  = slot_wr_data;
        end
    end

    // Response checker: every ACK must match the oldest expected response.
    always @(negedge clk) begin
        if (wb.ACK) begin
            ack_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ACK with dat %0h, expected none", wb.DAT_O);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_dat", 64'(wb.DAT_O), 64'(e.dat));
                chk("ack_bus_err", 64'(bus_err), 64'(e.err));
                chk("ack_latency", 64'(cyc - acc_cyc), 64'(e.lat));
            end
        end
    end

    task automatic wait_ack(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wb.ACK) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: ack not seen within 60 cycles, expected one", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
    endtask

    task automatic txn(input logic [15:0] addr, input logic we, input logic [31:0] wd,
                       input logic [31:0] exp_dat, input logic exp_err, input int exp_lat,
                       input int hold, input string name);
        exp_t e;
        e.dat = exp_dat;
        e.err = exp_err;
        e.lat = exp_lat;
        sb_q.push_back(e);
        @(negedge clk);
        wb.CYC = 1'b1; wb.STB = 1'b1; wb.WE = we; wb.ADDR = addr; wb.DAT_I = wd;
        @(posedge clk);
        acc_cyc = cyc;
        wait_ack(name);
        repeat (hold) @(negedge clk);
        wb.CYC = 1'b0; wb.STB = 1'b0; wb.WE = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 64'(wb.ACK), 64'h0);
        chk({tag, "_dat_o"}, 64'(wb.DAT_O), 64'h0);
        chk({tag, "_cs"}, slot_cs, 64'h0);
        chk({tag, "_rd"}, 64'(slot_rd), 64'h0);
        chk({tag, "_wr"}, 64'(slot_wr), 64'h0);
        chk({tag, "_reg"}, 64'(slot_reg_addr), 64'h0);
        chk({tag, "_wd"}, 64'(slot_wr_data), 64'h0);
        chk({tag, "_bus_err"}, 64'(bus_err), 64'h0);
        chk({tag, "_err_addr"}, 64'(err_addr), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s_rd, s_wr, s_cs, s_ack;
        exp_t e;
        for (int i = 0; i < 64; i++) slot_rd_data[i] = 32'h1000_0000 + 32'(i);
        slot_rd_data[3] = 32'h1234_5678;
        slot_rd_data[5] = 32'h5555_5555;
        slot_ready = '0;
        slot_ready[3] = 1'b1;
        err_clr = 1'b0;
        wb.CYC = 1'b0; wb.STB = 1'b0; wb.WE = 1'b0; wb.ADDR = '0; wb.DAT_I = '0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait read: slot 3, register 10.
        s_rd = rd_pulses; s_wr = wr_pulses;
        txn(16'h006A, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 2, 0, "zw_read");
        chk("zw_rd_pulses", 64'(rd_pulses - s_rd), 64'd1);
        chk("zw_wr_pulses", 64'(wr_pulses - s_wr), 64'd0);
        chk("zw_cs", cap_cs, 64'h8);
        chk("zw_reg", 64'(cap_reg), 64'd10);

        // Wait-state write: slot 5 ready four cycles after REQ.
        s_rd = rd_pulses; s_wr = wr_pulses;
        fork
            txn(16'h00A2, 1'b1, 32'h0000_00A5, 32'h0, 1'b0, 6, 0, "ws_write");
            begin
                @(negedge clk);
                @(posedge clk);
                repeat (4) @(posedge clk);
                @(negedge clk);
                slot_ready[5] = 1'b1;
            end
        join
        slot_ready[5] = 1'b0;
        chk("ws_wr_pulses", 64'(wr_pulses - s_wr), 64'd1);
        chk("ws_rd_pulses", 64'(rd_pulses - s_rd), 64'd0);
        chk("ws_wr_data", 64'(cap_wd), 64'hA5);
        chk("ws_cs", cap_cs, 64'h20);
        chk("ws_reg", 64'(cap_reg), 64'd2);

        // Timeout read on slot 7, then clear the flag.
        txn(16'h00E1, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 17, 0, "timeout");
        chk("to_bus_err", 64'(bus_err), 64'h1);
        chk("to_err_addr", 64'(err_addr), 64'hE1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("clr_bus_err", 64'(bus_err), 64'h0);
        chk("clr_err_addr", 64'(err_addr), 64'hE1);

        // err_clr coinciding with a new unmapped error: the error must win.
        fork
            txn(16'h0801, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 2, 0, "err_vs_clr");
            begin
                @(negedge clk);
                @(posedge clk);
                @(negedge clk) err_clr = 1'b1;
                @(negedge clk) err_clr = 1'b0;
            end
        join
        chk("evc_bus_err", 64'(bus_err), 64'h1);

        // Plain unmapped access: no chip select and no strobes.
        s_rd = rd_pulses; s_wr = wr_pulses; s_cs = cs_cycles;
        txn(16'h0800, 1'b1, 32'h1234, 32'hDEAD_BEEF, 1'b1, 2, 0, "unmapped");
        chk("um_rd_pulses", 64'(rd_pulses - s_rd), 64'd0);
        chk("um_wr_pulses", 64'(wr_pulses - s_wr), 64'd0);
        chk("um_cs_cycles", 64'(cs_cycles - s_cs), 64'd0);
        chk("um_err_addr", 64'(err_addr), 64'h800);

        // STB held for 10 cycles after ACK: exactly one ACK.
        s_ack = ack_cnt;
        txn(16'h0061, 1'b0, 32'h0, 32'h1234_5678, 1'b1, 2, 10, "held_stb");
        chk("held_ack_count", 64'(ack_cnt - s_ack), 64'd1);

        // CYC dropped while waiting on slot 7: abort without ACK.
        s_ack = ack_cnt;
        @(negedge clk);
        wb.CYC = 1'b1; wb.STB = 1'b1; wb.WE = 1'b0; wb.ADDR = 16'h00E3;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk) wb.CYC = 1'b0;
        @(negedge clk);
        chk("abort_cs", slot_cs, 64'h0);
        chk("abort_dat_o", 64'(wb.DAT_O), 64'h1234_5678);
        chk("abort_bus_err", 64'(bus_err), 64'h1);
        s_rd = rd_pulses; s_cs = cs_cycles;
        repeat (4) @(negedge clk);
        chk("stb_no_cyc_rd", 64'(rd_pulses - s_rd), 64'd0);
        chk("stb_no_cyc_cs", 64'(cs_cycles - s_cs), 64'd0);
        chk("abort_ack_count", 64'(ack_cnt - s_ack), 64'd0);
        wb.STB = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during WAIT, then a still-asserted request is accepted afresh.
        s_ack = ack_cnt;
        wb.CYC = 1'b1; wb.STB = 1'b1; wb.WE = 1'b0; wb.ADDR = 16'h00E1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        wb.ADDR = 16'h006A;
        repeat (2) @(negedge clk);
        chk("reset_ack_count", 64'(ack_cnt - s_ack), 64'd0);
        e.dat = 32'h1234_5678; e.err = 1'b0; e.lat = 2;
        sb_q.push_back(e);
        reset = 1'b0;
        @(posedge clk);
        acc_cyc = cyc;
        wait_ack("reaccept");
        wb.CYC = 1'b0; wb.STB = 1'b0;
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_mmio_ctrl.md
WB_MMIO_CTRL -- requirements
Module: wb_mmio_ctrl

Interface
REQ-001 SHALL take parameter N_SLOTS, default 64, the number of MMIO slots; it is fixed at 64 so the slot index is ADDR[10:5].
REQ-002 SHALL take parameter REG_AW, default 5, the register-address width within a slot; register index is ADDR[4:0].
REQ-003 SHALL take parameter TIMEOUT, default 16, the maximum number of cycles to wait for slot_ready before an error ACK.
REQ-004 SHALL take parameter ERR_DATA, default 32'hDEAD_BEEF, the read data returned on an error or unmapped access.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port wb, wishbone_if.slave: CYC, STB, WE, ADDR[MMIO_ADDR_WIDTH-1:0] (word address), DAT_I (write data), DAT_O (read data), ACK.
REQ-008 SHALL have port slot_cs, output, N_SLOTS bits: one-hot chip-select.
REQ-009 SHALL have port slot_rd, output, 1 bit: read strobe.
REQ-010 SHALL have port slot_wr, output, 1 bit: write strobe.
REQ-011 SHALL have port slot_reg_addr, output, REG_AW bits: register index.
REQ-012 SHALL have port slot_wr_data, output, 32 bits: write data.
REQ-013 SHALL have port slot_rd_data, input, N_SLOTS x 32 bits: per-slot read data.
REQ-014 SHALL have port slot_ready, input, N_SLOTS bits: slot completion flag; a slot may hold it high permanently for zero-wait operation.
REQ-015 SHALL have port err_clr, input, 1 bit: clears bus_err.
REQ-016 SHALL have port bus_err, output, 1 bit: sticky timeout/unmapped flag.
REQ-017 SHALL have port err_addr, output, MMIO_ADDR_WIDTH bits: word address of the most recent error.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, ACK, RELEASE, with all outputs registered.
REQ-019 In IDLE, CYC=1 and STB=1 at an edge SHALL latch ADDR, WE and DAT_I and move to REQ.
REQ-020 REQ SHALL last exactly 1 cycle: slot_cs one-hot for the latched slot, slot_rd=!WE or slot_wr=WE high for this cycle only, slot_reg_addr and slot_wr_data driven from the latched values.
REQ-021 slot_cs, slot_reg_addr and slot_wr_data SHALL stay valid from REQ through ACK, and return to 0 in RELEASE and IDLE.
REQ-022 slot_ready of the selected slot SHALL be sampled in REQ and WAIT; when high, the FSM SHALL capture slot_rd_data[slot] into DAT_O (reads) or 0 (writes) and go to ACK.
REQ-023 Minimum latency, from the STB-sampled edge to the ACK-high cycle, SHALL be 2 cycles.
REQ-024 A wait counter SHALL reset on entry to REQ and increment each cycle in REQ and WAIT.
REQ-025 If the count reaches TIMEOUT-1 without ready, the next state SHALL be ACK with DAT_O=ERR_DATA (reads or writes), bus_err<=1 and err_addr<=the latched address.
REQ-026 An unmapped address, i.e. ADDR bits above bit 10 nonzero, SHALL issue no slot_cs, rd or wr strobe; REQ SHALL go directly to ACK with ERR_DATA and set bus_err and err_addr.
REQ-027 ACK SHALL be high for exactly 1 cycle, then go to RELEASE.
REQ-028 DAT_O SHALL hold its value until the next ACK.
REQ-029 RELEASE SHALL wait until STB=0 or CYC=0 before going to IDLE; a request held high SHALL never be ACKed twice.
REQ-030 CYC=0 in REQ or WAIT SHALL abort to IDLE: no ACK, DAT_O unchanged, counter cleared, bus_err unchanged.
REQ-031 STB=1 with CYC=0 SHALL be ignored.
REQ-032 If err_clr and a new error occur in the same cycle, the error SHALL win (bus_err=1).
REQ-033 err_clr SHALL NOT modify err_addr.

Reset
REQ-034 reset=1 SHALL immediately force: state IDLE, ACK=0, DAT_O=0, slot_cs=0, slot_rd=0, slot_wr=0, slot_reg_addr=0, slot_wr_data=0, counter=0, bus_err=0, err_addr=0.
REQ-035 Reset asserted mid-transaction SHALL drop any pending ACK.
REQ-036 After reset release, a still-asserted STB SHALL be accepted as a new request.

Verification
REQ-037 Zero-wait read: slot 3 ready=1, rd_data[3]=32'h1234_5678, read ADDR=0x6A -> slot_cs=1<<3, reg_addr=10, slot_rd pulse 1 cycle, ACK 2 cycles after acceptance with DAT_O=32'h1234_5678.
REQ-038 Wait-state write: slot 5 ready rises 4 cycles after REQ, write DAT_I=0xA5 -> single slot_wr pulse with wr_data=0xA5, ACK after ready, DAT_O=0, bus_err=0.
REQ-039 Timeout: slot 7 ready=0, read -> ACK after TIMEOUT cycles with DAT_O=32'hDEAD_BEEF, bus_err=1, err_addr=latched address; pulsing err_clr -> bus_err=0.
REQ-040 Unmapped: ADDR=0x800 -> no cs or strobe, ACK 2 cycles after acceptance with ERR_DATA, bus_err=1.
REQ-041 Held STB and abort: STB held 10 cycles after ACK -> exactly one ACK; CYC dropped during WAIT -> no ACK, FSM in IDLE the next cycle.
REQ-042 Reset during WAIT: all outputs 0 immediately, no ACK.
